// File: rtl/mantissa_add_norm_if.sv
// ---------------------------------------------------------------------------
// mantissa_add_norm_if
// Operand/result bundle for mantissa_add_norm.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and payload stable until that edge.
// The consumer may drive ready independently of valid.
//   in_*  : operand side  (producer = upstream, consumer = adder)
//   out_* : result side   (producer = adder,    consumer = downstream)
//
// Modports
//   slave  : the adder (consumes operands, produces results)
//   master : the environment (drives operands, accepts results)
// ---------------------------------------------------------------------------
interface mantissa_add_norm_if #(
   parameter int MANTISSA_WIDTH = 23,
   parameter int EXP_WIDTH      = 8
);
   localparam int W = MANTISSA_WIDTH + 4;

   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         mantissa_a_in;
   logic [W-1:0]         mantissa_b_in;
   logic                 sign_a;
   logic                 sign_b;
   logic [EXP_WIDTH-1:0] exp_in;

   logic                 out_valid;
   logic                 out_ready;
   logic [W-1:0]         mantissa_out;
   logic [EXP_WIDTH-1:0] exp_out;
   logic                 sign_out;
   logic                 zero_flag;
   logic                 overflow_flag;
   logic                 underflow_flag;

   modport slave (
      input  in_valid, mantissa_a_in, mantissa_b_in, sign_a, sign_b, exp_in,
      input  out_ready,
      output in_ready,
      output out_valid, mantissa_out, exp_out, sign_out,
      output zero_flag, overflow_flag, underflow_flag
   );

   modport master (
      output in_valid, mantissa_a_in, mantissa_b_in, sign_a, sign_b, exp_in,
      output out_ready,
      input  in_ready,
      input  out_valid, mantissa_out, exp_out, sign_out,
      input  zero_flag, overflow_flag, underflow_flag
   );
endinterface

// File: rtl/mantissa_add_norm.sv
// ---------------------------------------------------------------------------
// mantissa_add_norm
// Adds/subtracts two pre-aligned mantissas (hidden bit, fraction, G/R/S)
// sharing one exponent, then normalizes the result so the hidden bit sits
// at bit W-1 (W = MANTISSA_WIDTH + 4).
//
// Ports
//   clk        : clock, rising edge
//   arst_n     : asynchronous active-low reset
//   bus        : mantissa_add_norm_if.slave (operand and result handshakes,
//                result data and status flags)
//   dbg_state  : current FSM state (0 IDLE, 1 ADD, 2 NORM, 3 DONE)
//
// Build option
//   MANTISSA_FAST_NORM_EN : when defined, NORM finishes in one cycle with a
//   leading-zero-count shift clamped to the exponent. When undefined, NORM
//   shifts one bit per cycle. Results are identical; only latency differs.
// ---------------------------------------------------------------------------
module mantissa_add_norm #(
   parameter int MANTISSA_WIDTH = 23,
   parameter int EXP_WIDTH      = 8
) (
   input  logic                clk,
   input  logic                arst_n,
   mantissa_add_norm_if.slave  bus,
   output logic [1:0]          dbg_state
);

   localparam int W = MANTISSA_WIDTH + 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;

   // Captured operands
   logic [W-1:0]         a_q, a_d;
   logic [W-1:0]         b_q, b_d;
   logic                 sa_q, sa_d;
   logic                 sb_q, sb_d;

   // Working result; these registers drive the outputs directly
   logic [W-1:0]         mant_q, mant_d;
   logic [EXP_WIDTH-1:0] exp_q, exp_d;
   logic                 sign_q, sign_d;
   logic                 zf_q, zf_d;
   logic                 of_q, of_d;
   logic                 uf_q, uf_d;

   // Arithmetic helpers
   logic [W:0]           sum_w;
   logic                 a_ge_b;
   logic [W-1:0]         diff_w;
   logic [EXP_WIDTH-1:0] exp_inc;
   logic [W-1:0]         norm_mant;
   logic [EXP_WIDTH-1:0] norm_exp;
   logic                 norm_uf;

`ifdef MANTISSA_FAST_NORM_EN
   localparam int CW = $clog2(W + 1);
   localparam int SW = (CW > EXP_WIDTH) ? CW : EXP_WIDTH;

   logic [SW-1:0] lz_ext;
   logic [SW-1:0] exp_ext;
   logic [SW-1:0] shamt;

   // Number of zeros above the highest set bit (W when v is zero).
   function automatic logic [CW-1:0] lzc(input logic [W-1:0] v);
      logic [CW-1:0] n;
      n = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (v[i]) n = CW'(W - 1 - i);
      end
      return n;
   endfunction

   always_comb begin
      lz_ext  = SW'(lzc(mant_q));
      exp_ext = SW'(exp_q);
      // Never shift past exponent 0; the remainder shows up as underflow.
      shamt     = (lz_ext < exp_ext) ? lz_ext : exp_ext;
      norm_mant = mant_q << shamt;
      norm_exp  = exp_q - EXP_WIDTH'(shamt);
      // Hidden bit still clear after the clamped shift means we ran out of
      // exponent before normalizing.
      norm_uf   = ~norm_mant[W-1];
   end
`else
   always_comb begin
      norm_mant = mant_q << 1;
      norm_exp  = exp_q - EXP_WIDTH'(1);
      norm_uf   = ~norm_mant[W-1] && (norm_exp == '0);
   end
`endif

   // Datapath arithmetic used in ADD
   always_comb begin
      sum_w   = {1'b0, a_q} + {1'b0, b_q};
      a_ge_b  = (a_q >= b_q);
      diff_w  = a_ge_b ? (a_q - b_q) : (b_q - a_q);
      exp_inc = exp_q + EXP_WIDTH'(1);
   end

   // Next-state and next-datapath logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      zf_d    = zf_q;
      of_d    = of_q;
      uf_d    = uf_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.mantissa_a_in;
               b_d     = bus.mantissa_b_in;
               sa_d    = bus.sign_a;
               sb_d    = bus.sign_b;
               exp_d   = bus.exp_in;
               mant_d  = '0;
               sign_d  = 1'b0;
               zf_d    = 1'b0;
               of_d    = 1'b0;
               uf_d    = 1'b0;
               state_d = ADD;
            end
         end

         ADD: begin
            if (sa_q == sb_q) begin
               sign_d = sa_q;
               if (sum_w[W]) begin
                  // Carry out: shift right one, folding the two lowest bits
                  // into the new sticky bit.
                  exp_d   = exp_inc;
                  state_d = DONE;
                  if (&exp_inc) begin
                     of_d   = 1'b1;
                     mant_d = '0;
                  end else begin
                     mant_d = {sum_w[W:2], sum_w[1] | sum_w[0]};
                  end
               end else begin
                  mant_d = sum_w[W-1:0];
                  if (!sum_w[W-1] && (sum_w[W-1:0] != '0) && (exp_q != '0))
                     state_d = NORM;
                  else
                     state_d = DONE;
               end
            end else begin
               if (diff_w == '0) begin
                  zf_d    = 1'b1;
                  mant_d  = '0;
                  exp_d   = '0;
                  sign_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  // The larger magnitude decides the sign.
                  sign_d = a_ge_b ? sa_q : sb_q;
                  mant_d = diff_w;
                  if (!diff_w[W-1] && (exp_q != '0))
                     state_d = NORM;
                  else
                     state_d = DONE;
               end
            end
         end

         NORM: begin
            mant_d = norm_mant;
            exp_d  = norm_exp;
`ifdef MANTISSA_FAST_NORM_EN
            uf_d    = norm_uf;
            state_d = DONE;
`else
            if (norm_mant[W-1] || (norm_exp == '0)) begin
               uf_d    = norm_uf;
               state_d = DONE;
            end
`endif
         end

         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         mant_q <= '0;
         exp_q  <= '0;
         sign_q <= 1'b0;
         zf_q   <= 1'b0;
         of_q   <= 1'b0;
         uf_q   <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         mant_q <= mant_d;
         exp_q  <= exp_d;
         sign_q <= sign_d;
         zf_q   <= zf_d;
         of_q   <= of_d;
         uf_q   <= uf_d;
      end
   end

   // Handshake flags decode straight from state so reset acts immediately.
   assign bus.in_ready       = (state_q == IDLE);
   assign bus.out_valid      = (state_q == DONE);
   assign bus.mantissa_out   = mant_q;
   assign bus.exp_out        = exp_q;
   assign bus.sign_out       = sign_q;
   assign bus.zero_flag      = zf_q;
   assign bus.overflow_flag  = of_q;
   assign bus.underflow_flag = uf_q;
   assign dbg_state          = state_q;

endmodule

// File: doc/mantissa_add_norm.md
MANTISSA_ADD_NORM -- requirements
Module: mantissa_add_norm

Interface
REQ-001 Parameter MANTISSA_WIDTH, default 23, is the stored fraction width; the operand width W = MANTISSA_WIDTH+4, made up of the hidden bit, the fraction, and guard/round/sticky bits.
REQ-002 Parameter EXP_WIDTH, default 8, is the biased exponent width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 arst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  input operands valid.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 mantissa_a_in, mantissa_b_in  in  W each  aligned operands from the upstream shifter.
REQ-008 sign_a, sign_b  in  1 each  operand signs.
REQ-009 exp_in  in  EXP_WIDTH  common (larger) exponent.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 mantissa_out  out  W  normalized mantissa, hidden bit at bit W-1.
REQ-013 exp_out  out  EXP_WIDTH  adjusted exponent.
REQ-014 sign_out  out  1  result sign.
REQ-015 zero_flag, overflow_flag, underflow_flag  out  1 each  status flags.

Function
REQ-016 The FSM SHALL have four states: IDLE, ADD, NORM and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-017 When in_valid and in_ready are both 1 at an edge, the block SHALL register all inputs and move to ADD; in_valid is ignored in every other state.
REQ-018 In ADD, when sign_a equals sign_b, the block SHALL form a (W+1)-bit sum with sign equal to sign_a.
REQ-019 In ADD, when the signs differ, the block SHALL subtract the smaller mantissa from the larger (unsigned compare); sign_out takes the sign of the larger mantissa.
REQ-020 On carry-out (bit W of the sum set), the block SHALL shift right 1 bit, set the new LSB to the OR of the old bit0 and bit1 (sticky), and increment the exponent.
REQ-021 If that increment reaches all-ones, the block SHALL set overflow_flag=1 and mantissa_out=0.
REQ-022 If a subtraction result is 0, the block SHALL set zero_flag=1, mantissa_out=0, exp_out=0 and sign_out=0, and go to DONE.
REQ-023 From ADD, the block SHALL go to NORM if bit W-1 of the result is 0, the result is nonzero and the exponent is greater than 0; otherwise it SHALL go to DONE.
REQ-024 In NORM, each cycle the block SHALL shift the mantissa left 1 (zero fill) and decrement the exponent; it leaves NORM when bit W-1 becomes 1 or the exponent reaches 0.
REQ-025 Reaching exponent 0 with bit W-1 still 0 SHALL set underflow_flag=1, with the mantissa kept as shifted.
REQ-026 Latency, from the accept edge to out_valid high: 2 cycles with no normalization, plus 1 cycle per NORM shift.
REQ-027 In DONE, all outputs SHALL hold stable until out_ready=1; the block then returns to IDLE on the next edge, with in_ready=1 in the following cycle and no accept in the same cycle as the handoff.
REQ-028 All flags SHALL be cleared when a new operand pair is accepted.

Reset
REQ-029 When arst_n=0, the block SHALL immediately enter IDLE, with in_ready=1, out_valid=0, and all data outputs and flags equal to 0, regardless of the current state, including mid-NORM.
REQ-030 The first accept after reset SHALL be possible on the first rising edge with arst_n=1.

Configuration
REQ-031 Macro MANTISSA_FAST_NORM_EN defined: NORM SHALL complete in exactly one cycle, using a leading-zero count shift clamped to the exponent, so latency is at most 3 cycles.
REQ-032 Macro MANTISSA_FAST_NORM_EN undefined: normalization SHALL be iterative, 1 bit per cycle, as in REQ-024. Results are identical in both builds; only latency differs.

Verification
(MANTISSA_WIDTH=23, W=27; "iterative" means MANTISSA_FAST_NORM_EN undefined.)
REQ-033 Same-sign add: a=b=27'h4000000, exp 127 -> mantissa 27'h4000000, exp 128, out_valid 2 cycles after accept.
REQ-034 Same-sign sticky carry: a=27'h4000001, b=27'h4000000, exp 127 -> mantissa 27'h4000001, exp 128.
REQ-035 Normalizing subtract: a=27'h4000000 (+), b=27'h2000000 (-), exp 127 -> mantissa 27'h4000000, exp 126, sign 0. out_valid comes 3 cycles after accept in both builds, since only one shift is needed.
REQ-036 Equal subtract: a=b=27'h5000000 with opposite signs -> zero_flag=1, mantissa 0, exp 0, sign 0.
REQ-037 Underflow: a=27'h4000000 (+), b=27'h3FFFFFF (-), exp 2, iterative -> 2 NORM cycles, exp_out 0, underflow_flag=1.
REQ-038 Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout. Then assert arst_n=0 during NORM -> out_valid=0 and in_ready=1 immediately.
